eq_gain_ctrl: RTL and testbench



---
 rtl/eq_gain_ctrl_if.sv | 31 +++
 rtl/eq_gain_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_eq_gain_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eq_gain_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : eq_gain_ctrl_if
// Function : valid/ready gain-update channel from the equaliser UI controller
//            to the DSP gain port. master = controller, slave = DSP.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
interface eq_gain_ctrl_if #(
  parameter int BAND_W = 3,
  parameter int GAIN_W = 16
);
  logic              upd_valid;
  logic [BAND_W-1:0] upd_band;
  logic [GAIN_W-1:0] upd_gain;
  logic              upd_ready;

  modport master (
    output upd_valid,
    output upd_band,
    output upd_gain,
    input  upd_ready
  );

  modport slave (
    input  upd_valid,
    input  upd_band,
    input  upd_gain,
    output upd_ready
  );
endinterface
`default_nettype wire

// File: rtl/eq_gain_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : eq_gain_ctrl
// Function : N-band equaliser user-interface controller. Sequences codec
//            initialisation, flushes all band gains to the DSP, and runs the
//            band-select / gain-set menu from debounced key pulses. Gain
//            changes leave over a single-outstanding valid/ready channel.
// Options  : EQ_LIVE_UPDATE_EN - every effective gain step is sent to the DSP
//            immediately and leaving SET_GAIN sends no commit.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
module eq_gain_ctrl #(
  parameter int N_BAND   = 7,
  parameter int GAIN_W   = 16,
  parameter int GAIN_MAX = 12,
  parameter int GAIN_MIN = -11,
  parameter int BAND_W   = $clog2(N_BAND)
) (
  input  wire logic              i_clk,
  input  wire logic              i_rst_n,
  input  wire logic              i_init_done,
  input  wire logic              i_select,
  input  wire logic              i_back,
  input  wire logic              i_up,
  input  wire logic              i_down,
  output logic                   o_init_start,
  output logic [2:0]             o_state,
  output logic [BAND_W-1:0]      o_band,
  output logic [GAIN_W-1:0]      o_gain,
  eq_gain_ctrl_if.master         upd
);

  // Flush counter must be able to hold N_BAND ("all bands loaded").
  localparam int                        C_K_W      = $clog2(N_BAND + 1);
  localparam logic [C_K_W-1:0]          C_K_ALL    = C_K_W'(N_BAND);
  localparam logic [BAND_W-1:0]         C_BAND_TOP = BAND_W'(N_BAND - 1);
  localparam logic signed [GAIN_W-1:0]  C_GAIN_MAX = $signed(GAIN_W'(GAIN_MAX));
  localparam logic signed [GAIN_W-1:0]  C_GAIN_MIN = $signed(GAIN_W'(GAIN_MIN));

  typedef enum logic [2:0] {
    ST_INIT     = 3'd0,
    ST_FLUSH    = 3'd1,
    ST_IDLE     = 3'd2,
    ST_BAND_SEL = 3'd3,
    ST_SET_GAIN = 3'd4
  } state_t;

  state_t                     r_state;
  logic                       r_init_start;
  logic [BAND_W-1:0]          r_band;
  logic signed [GAIN_W-1:0]   r_gain [N_BAND];
  logic [GAIN_W-1:0]          r_gain_out;
  logic [C_K_W-1:0]           r_flush_k;
  logic                       r_upd_valid;
  logic [BAND_W-1:0]          r_upd_band;
  logic [GAIN_W-1:0]          r_upd_gain;

  state_t                     w_state_nxt;
  logic                       w_init_start_nxt;
  logic [BAND_W-1:0]          w_band_nxt;
  logic signed [GAIN_W-1:0]   w_gain_nxt [N_BAND];
  logic [C_K_W-1:0]           w_flush_k_nxt;
  logic                       w_accept;
  logic                       w_slot_free;
  logic                       w_load;
  logic [BAND_W-1:0]          w_load_band;
  logic [GAIN_W-1:0]          w_load_gain;
  logic signed [GAIN_W-1:0]   w_cur_gain;

  // A transfer happens on this edge; the slot is free if nothing is
  // outstanding or the outstanding update leaves on this edge.
  assign w_accept    = r_upd_valid & upd.upd_ready;
  assign w_slot_free = ~r_upd_valid | upd.upd_ready;
  assign w_cur_gain  = r_gain[r_band];

  // Next-state, menu actions and update-payload selection.
  always_comb begin
    w_state_nxt      = r_state;
    w_init_start_nxt = r_init_start;
    w_band_nxt       = r_band;
    w_gain_nxt       = r_gain;
    w_flush_k_nxt    = r_flush_k;
    w_load           = 1'b0;
    w_load_band      = '0;
    w_load_gain      = '0;

    unique case (r_state)
      ST_INIT: begin
        if (i_init_done) begin
          w_state_nxt      = ST_FLUSH;
          w_init_start_nxt = 1'b0;
          w_flush_k_nxt    = '0;
        end
      end

      ST_FLUSH: begin
        // Once every band is loaded, the outstanding update is the last flush
        // entry, so its acceptance finishes the flush.
        if (r_flush_k == C_K_ALL) begin
          if (w_accept) begin
            w_state_nxt = ST_IDLE;
          end
        end else if (w_slot_free) begin
          w_load        = 1'b1;
          w_load_band   = r_flush_k[BAND_W-1:0];
          w_load_gain   = r_gain[r_flush_k[BAND_W-1:0]];
          w_flush_k_nxt = r_flush_k + C_K_W'(1);
        end
      end

      ST_IDLE: begin
        if (i_select) begin
          w_state_nxt = ST_BAND_SEL;
          w_band_nxt  = '0;
        end else if (i_back) begin
          // Reset-all: zero every band and re-send the whole table.
          for (int i = 0; i < N_BAND; i++) begin
            w_gain_nxt[i] = '0;
          end
          w_state_nxt   = ST_FLUSH;
          w_flush_k_nxt = '0;
        end
      end

      ST_BAND_SEL: begin
        if (i_select) begin
          w_state_nxt = ST_SET_GAIN;
        end else if (i_back) begin
          w_state_nxt = ST_IDLE;
          w_band_nxt  = '0;
        end else if (i_up) begin
          if (r_band != C_BAND_TOP) begin
            w_band_nxt = r_band + BAND_W'(1);
          end
        end else if (i_down) begin
          if (r_band != '0) begin
            w_band_nxt = r_band - BAND_W'(1);
          end
        end
      end

      ST_SET_GAIN: begin
        if (i_select || i_back) begin
          // Leaving is held off while an earlier update still waits.
          if (w_slot_free) begin
            w_state_nxt = ST_BAND_SEL;
`ifndef EQ_LIVE_UPDATE_EN
            w_load      = 1'b1;
            w_load_band = r_band;
            w_load_gain = w_cur_gain;
`endif
          end
        end else if (i_up) begin
          if (w_cur_gain < C_GAIN_MAX) begin
`ifdef EQ_LIVE_UPDATE_EN
            if (w_slot_free) begin
              w_gain_nxt[r_band] = w_cur_gain + GAIN_W'(1);
              w_load             = 1'b1;
              w_load_band        = r_band;
              w_load_gain        = w_cur_gain + GAIN_W'(1);
            end
`else
            w_gain_nxt[r_band] = w_cur_gain + GAIN_W'(1);
`endif
          end
        end else if (i_down) begin
          if (w_cur_gain > C_GAIN_MIN) begin
`ifdef EQ_LIVE_UPDATE_EN
            if (w_slot_free) begin
              w_gain_nxt[r_band] = w_cur_gain - GAIN_W'(1);
              w_load             = 1'b1;
              w_load_band        = r_band;
              w_load_gain        = w_cur_gain - GAIN_W'(1);
            end
`else
            w_gain_nxt[r_band] = w_cur_gain - GAIN_W'(1);
`endif
          end
        end
      end

      default: begin
        w_state_nxt = ST_INIT;
      end
    endcase
  end

  // State, gain table, registered display outputs and update channel.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_INIT;
      r_init_start <= 1'b1;
      r_band       <= '0;
      for (int i = 0; i < N_BAND; i++) begin
        r_gain[i] <= '0;
      end
      r_gain_out   <= '0;
      r_flush_k    <= '0;
      r_upd_valid  <= 1'b0;
      r_upd_band   <= '0;
      r_upd_gain   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_init_start <= w_init_start_nxt;
      r_band       <= w_band_nxt;
      r_gain       <= w_gain_nxt;
      r_gain_out   <= w_gain_nxt[w_band_nxt];
      r_flush_k    <= w_flush_k_nxt;
      // A new payload may replace one accepted on the same edge.
      if (w_load) begin
        r_upd_valid <= 1'b1;
        r_upd_band  <= w_load_band;
        r_upd_gain  <= w_load_gain;
      end else if (w_accept) begin
        r_upd_valid <= 1'b0;
      end
    end
  end

  assign o_init_start  = r_init_start;
  assign o_state       = r_state;
  assign o_band        = r_band;
  assign o_gain        = r_gain_out;
  assign upd.upd_valid = r_upd_valid;
  assign upd.upd_band  = r_upd_band;
  assign upd.upd_gain  = r_upd_gain;

endmodule
`default_nettype wire

// File: tb/tb_eq_gain_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_eq_gain_ctrl
// Function : directed self-checking bench for eq_gain_ctrl with a behavioural
//            menu model compared every cycle, plus hand-computed checks.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_eq_gain_ctrl;
  localparam int N      = 7;
  localparam int BW     = 3;
  localparam int GW     = 16;
  localparam int GMAX   = 12;
  localparam int GMIN   = -11;
`ifdef EQ_LIVE_UPDATE_EN
  localparam bit LIVE = 1'b1;
`else
  localparam bit LIVE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic init_done = 1'b0;
  logic sel = 1'b0, bk = 1'b0, up = 1'b0, dn = 1'b0;
  logic ready = 1'b1;
  logic          o_init_start;
  logic [2:0]    o_state;
  logic [BW-1:0] o_band;
  logic [GW-1:0] o_gain;

  eq_gain_ctrl_if #(.BAND_W(BW), .GAIN_W(GW)) u_if ();
  assign u_if.upd_ready = ready;

  eq_gain_ctrl #(.N_BAND(N), .GAIN_W(GW), .GAIN_MAX(GMAX), .GAIN_MIN(GMIN)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_init_done(init_done),
    .i_select(sel), .i_back(bk), .i_up(up), .i_down(dn),
    .o_init_start(o_init_start), .o_state(o_state), .o_band(o_band),
    .o_gain(o_gain), .upd(u_if)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc_no = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc_no);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_state, m_band, m_init_start;
  int m_gain [N];
  bit m_valid;
  int m_ub, m_ug;
  int fq[$];   // bands still to be sent by the current flush

  task automatic m_reset();
    m_state = 0; m_band = 0; m_init_start = 1;
    foreach (m_gain[i]) m_gain[i] = 0;
    m_valid = 0; m_ub = 0; m_ug = 0;
    fq = {};
  endtask

  task automatic m_fill();
    fq = {};
    for (int i = 0; i < N; i++) fq.push_back(i);
  endtask

  task automatic m_step();
    bit acc, free, ld;
    int lb, lg, g, ng;
    acc = m_valid && ready;
    free = !m_valid || ready;
    ld = 0; lb = 0; lg = 0;
    case (m_state)
      0: if (init_done) begin m_state = 1; m_init_start = 0; m_fill(); end
      1: begin
        if (fq.size() != 0) begin
          if (free) begin lb = fq.pop_front(); lg = m_gain[lb]; ld = 1; end
        end else if (acc) m_state = 2;
      end
      2: begin
        if (sel) begin m_state = 3; m_band = 0; end
        else if (bk) begin foreach (m_gain[i]) m_gain[i] = 0; m_state = 1; m_fill(); end
      end
      3: begin
        if (sel) m_state = 4;
        else if (bk) begin m_state = 2; m_band = 0; end
        else if (up) m_band = (m_band + 1 > N - 1) ? N - 1 : m_band + 1;
        else if (dn) m_band = (m_band - 1 < 0) ? 0 : m_band - 1;
      end
      4: begin
        g = m_gain[m_band];
        if (sel || bk) begin
          if (free) begin
            m_state = 3;
            if (!LIVE) begin ld = 1; lb = m_band; lg = g; end
          end
        end else if (up || dn) begin
          ng = up ? ((g + 1 > GMAX) ? GMAX : g + 1) : ((g - 1 < GMIN) ? GMIN : g - 1);
          if (ng != g) begin
            if (!LIVE) m_gain[m_band] = ng;
            else if (free) begin m_gain[m_band] = ng; ld = 1; lb = m_band; lg = ng; end
          end
        end
      end
      default: ;
    endcase
    if (ld) begin m_valid = 1; m_ub = lb; m_ug = lg; end
    else if (acc) m_valid = 0;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else m_step();
    end
  end

  // ---------------- per-cycle compare + transfer log ----------------
  int lg_band[$], lg_gain[$], lg_cyc[$];

  initial begin
    forever begin
      @(negedge clk);
      cyc_no++;
      chk("state", 32'(o_state), 32'(m_state));
      chk("init_start", 32'(o_init_start), 32'(m_init_start));
      chk("band", 32'(o_band), 32'(m_band));
      chk("gain", 32'(o_gain), {16'h0, 16'(m_gain[m_band])});
      chk("upd_valid", 32'(u_if.upd_valid), 32'(m_valid));
      if (m_valid) begin
        chk("upd_band", 32'(u_if.upd_band), 32'(m_ub));
        chk("upd_gain", 32'(u_if.upd_gain), {16'h0, 16'(m_ug)});
      end
      if (rst_n && u_if.upd_valid && ready) begin
        lg_band.push_back(int'(u_if.upd_band));
        lg_gain.push_back(int'(u_if.upd_gain));
        lg_cyc.push_back(cyc_no);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic press(input bit s, input bit b, input bit u, input bit d);
    sel = s; bk = b; up = u; dn = d;
    step();
    sel = 0; bk = 0; up = 0; dn = 0;
  endtask

  task automatic press_n(input bit u, input bit d, input int n);
    for (int i = 0; i < n; i++) press(0, 0, u, d);
  endtask

  // Waits for IDLE after a flush entry edge; returns edges taken.
  task automatic wait_idle(input string nm, output int n);
    n = 0;
    while (o_state != 3'd2 && n < 40) begin step(); n++; end
    if (n >= 40) begin
      total++; bad++;
      $display("FAIL %s_timeout: got state %0d expected 2", nm, o_state);
    end
  endtask

  task automatic check_flush(input string nm, input int base);
    chk({nm, "_count"}, 32'(lg_band.size() - base), 32'd7);
    if (lg_band.size() - base >= 7) begin
      for (int i = 0; i < 7; i++) begin
        chk({nm, "_band"}, 32'(lg_band[base + i]), 32'(i));
        chk({nm, "_gain"}, 32'(lg_gain[base + i]), 32'd0);
        chk({nm, "_consec"}, 32'(lg_cyc[base + i] - lg_cyc[base]), 32'(i));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int base, n;
    step(); step();
    chk("rst_state", 32'(o_state), 32'd0);
    chk("rst_init_start", 32'(o_init_start), 32'd1);
    chk("rst_valid", 32'(u_if.upd_valid), 32'd0);
    chk("rst_gain", 32'(o_gain), 32'd0);
    rst_n = 1; step(); step();

    // Initialisation handshake and first flush
    init_done = 1;
    base = lg_band.size();
    step();
    chk("init_start_fall", 32'(o_init_start), 32'd0);
    chk("enter_flush", 32'(o_state), 32'd1);
    wait_idle("flush0", n);
    chk("flush0_cycles", 32'(n), 32'd8);
    check_flush("flush0", base);

    // Band 2 gain to saturation
    press(1, 0, 0, 0);
    press_n(1, 0, 2);
    press(1, 0, 0, 0);
    press_n(1, 0, 15);
    chk("sat_band", 32'(o_band), 32'd2);
    chk("sat_gain", 32'(o_gain), 32'd12);
    chk("sat_state", 32'(o_state), 32'd4);
    base = lg_band.size();
    press(0, 1, 0, 0);
    chk("exit_state", 32'(o_state), 32'd3);
    step();
    if (!LIVE) begin
      chk("commit_count", 32'(lg_band.size() - base), 32'd1);
      if (lg_band.size() > base) begin
        chk("commit_band", 32'(lg_band[base]), 32'd2);
        chk("commit_gain", 32'(lg_gain[base]), 32'd12);
      end
    end else begin
      chk("live_exit_no_upd", 32'(lg_band.size() - base), 32'd0);
    end

    // Exit blocked by a pending update while ready is low
    ready = 0;
    press(1, 0, 0, 0);
    if (!LIVE) begin
      press(0, 1, 0, 0);
      chk("pending_exit_state", 32'(o_state), 32'd3);
      press(1, 0, 0, 0);
    end else begin
      press(0, 0, 0, 1);
    end
    press(1, 0, 0, 0);
    chk("blocked_exit", 32'(o_state), 32'd4);
    ready = 1;
    base = lg_band.size();
    step();
    chk("blocked_xfer", 32'(lg_band.size() - base), 32'd1);
    press(1, 0, 0, 0);
    chk("unblocked_exit", 32'(o_state), 32'd3);

    // Band saturation, gain floor, simultaneous keys
    press_n(1, 0, 10);
    chk("band_top", 32'(o_band), 32'd6);
    press(1, 0, 0, 0);
    press_n(0, 1, 30);
    chk("gain_floor", 32'(o_gain), 32'h0000FFF5);
    press(0, 0, 1, 1);
    chk("up_wins", 32'(o_gain), 32'h0000FFF6);
    press(0, 1, 0, 0);
    press(1, 0, 1, 0);
    chk("select_wins_state", 32'(o_state), 32'd4);
    chk("select_wins_band", 32'(o_band), 32'd6);
    press(0, 1, 0, 0);
    press(0, 1, 0, 0);
    chk("back_idle", 32'(o_state), 32'd2);
    chk("idle_band", 32'(o_band), 32'd0);

    // Reset-all from IDLE
    step();
    base = lg_band.size();
    press(0, 1, 0, 0);
    chk("resetall_flush", 32'(o_state), 32'd1);
    wait_idle("flush_all", n);
    chk("flush_all_cycles", 32'(n), 32'd8);
    check_flush("flush_all", base);
    press(1, 0, 0, 0);
    press_n(1, 0, 2);
    chk("gain_cleared", 32'(o_gain), 32'd0);
    press(0, 1, 0, 0);

    // Asynchronous reset in the middle of a flush
    press(0, 1, 0, 0);
    step(); step(); step();
    rst_n = 0;
    #1;
    chk("async_valid", 32'(u_if.upd_valid), 32'd0);
    chk("async_state", 32'(o_state), 32'd0);
    chk("async_init_start", 32'(o_init_start), 32'd1);
    step();
    rst_n = 1;
    step();
    base = lg_band.size();
    wait_idle("flush_rst", n);
    check_flush("flush_rst", base);

    // Steps on band 1: live updates or a single commit
    press(1, 0, 0, 0);
    press(0, 0, 1, 0);
    press(1, 0, 0, 0);
    base = lg_band.size();
    press_n(1, 0, 3);
    step();
    if (LIVE) begin
      chk("live_count", 32'(lg_band.size() - base), 32'd3);
      if (lg_band.size() - base >= 3) begin
        for (int i = 0; i < 3; i++) begin
          chk("live_band", 32'(lg_band[base + i]), 32'd1);
          chk("live_gain", 32'(lg_gain[base + i]), 32'(i + 1));
        end
      end
    end else begin
      chk("no_live_count", 32'(lg_band.size() - base), 32'd0);
    end
    press(0, 1, 0, 0);
    step();
    if (LIVE) begin
      chk("live_exit_count", 32'(lg_band.size() - base), 32'd3);
    end else begin
      chk("b1_commit_count", 32'(lg_band.size() - base), 32'd1);
      if (lg_band.size() > base) begin
        chk("b1_commit_band", 32'(lg_band[base]), 32'd1);
        chk("b1_commit_gain", 32'(lg_gain[base]), 32'd3);
      end
    end
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
